// File: rtl/maze_generator.sv
// Binary-tree maze generator: carves one cell per clock into a STRIDE x STRIDE
// tile bitmap (1 = path), with a 16-bit Galois LFSR choosing north/east.
module maze_generator #(
    parameter int          STRIDE       = 100,
    parameter int          MAX_CELLS    = 49,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [5:0]                 cells_w,
    input  logic [5:0]                 cells_h,
    input  logic [15:0]                seed,
    output logic [STRIDE*STRIDE-1:0]   path_data,
    output logic [6:0]                 maze_width,
    output logic [6:0]                 maze_height,
    output logic                       busy,
    output logic                       done,
    output logic                       valid
);

    localparam int          NBITS     = STRIDE * STRIDE;
    localparam int          IW        = ($clog2(NBITS) > 14) ? $clog2(NBITS) : 14;
    localparam logic [5:0]  MAXC      = 6'(MAX_CELLS);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CARVE, S_FINISH} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [5:0]            r_w;
    logic [5:0]            r_h;
    logic [5:0]            r_i;
    logic [5:0]            r_j;
    logic [15:0]           r_lfsr;
    logic [NBITS-1:0]      r_path;
    logic [6:0]            r_mw;
    logic [6:0]            r_mh;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_clear;
    logic                  w_carve;
    logic                  w_finish;
    logic [5:0]            w_cw_clamped;
    logic [5:0]            w_ch_clamped;
    logic                  w_east_edge;
    logic                  w_top_row;
    logic                  w_last;
    logic                  w_do_east;
    logic                  w_do_north;
    logic [IW-1:0]         w_cell_idx;
    logic [IW-1:0]         w_wall_idx;
    logic [IW-1:0]         w_exit_idx;
    logic [15:0]           w_lfsr_step;

    function automatic logic [5:0] clamp_cells(input logic [5:0] v);
        if (v == 6'd0)
            return 6'd1;
        else if (v > MAXC)
            return MAXC;
        else
            return v;
    endfunction

    // Linear bit address of tile (x,y); always inside the bitmap since x,y <= 2*MAX_CELLS.
    function automatic logic [IW-1:0] tile_idx(input logic [6:0] x, input logic [6:0] y);
        return IW'(x) + IW'(STRIDE) * IW'(y);
    endfunction

    assign w_cw_clamped = clamp_cells(cells_w);
    assign w_ch_clamped = clamp_cells(cells_h);

    assign w_east_edge = (r_i == r_w - 6'd1);
    assign w_top_row   = (r_j == 6'd0);
    assign w_last      = w_east_edge && (r_j == r_h - 6'd1);

    // Top row is forced east, rightmost column forced north, corner carves nothing.
    assign w_do_east  = !w_east_edge && (w_top_row || r_lfsr[0]);
    assign w_do_north = !w_top_row && (w_east_edge || !r_lfsr[0]);

    assign w_cell_idx = tile_idx({r_i, 1'b1}, {r_j, 1'b1});
    assign w_wall_idx = w_do_east ? tile_idx({r_i, 1'b0} + 7'd2, {r_j, 1'b1})
                                  : tile_idx({r_i, 1'b1}, {r_j, 1'b0});
    assign w_exit_idx = tile_idx({r_w, 1'b0}, {r_h, 1'b0} - 7'd1);

    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_CLEAR;
            S_CLEAR:  w_state_next = S_CARVE;
            S_CARVE:  if (w_last) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_clear  = 1'b0;
        w_carve  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE:   w_accept = start;
            S_CLEAR:  w_clear  = 1'b1;
            S_CARVE:  w_carve  = 1'b1;
            S_FINISH: w_finish = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w     <= 6'd0;
            r_h     <= 6'd0;
            r_i     <= 6'd0;
            r_j     <= 6'd0;
            r_lfsr  <= DEFAULT_SEED;
            r_path  <= '0;
            r_mw    <= 7'd0;
            r_mh    <= 7'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_w     <= w_cw_clamped;
                r_h     <= w_ch_clamped;
                r_lfsr  <= (seed == 16'd0) ? DEFAULT_SEED : seed;
                r_mw    <= {w_cw_clamped, 1'b1};
                r_mh    <= {w_ch_clamped, 1'b1};
                r_busy  <= 1'b1;
                r_valid <= 1'b0;
            end
            if (w_clear) begin
                r_path <= '0;
                r_i    <= 6'd0;
                r_j    <= 6'd0;
            end
            if (w_carve) begin
                r_path[w_cell_idx] <= 1'b1;
                if (w_do_east || w_do_north)
                    r_path[w_wall_idx] <= 1'b1;
                r_lfsr <= w_lfsr_step;
                if (w_east_edge) begin
                    r_i <= 6'd0;
                    r_j <= r_j + 6'd1;
                end else begin
                    r_i <= r_i + 6'd1;
                end
            end
            if (w_finish) begin
                r_path[IW'(STRIDE)] <= 1'b1;
                r_path[w_exit_idx]  <= 1'b1;
                r_busy              <= 1'b0;
                r_valid             <= 1'b1;
            end
        end
    end

    assign path_data   = r_path;
    assign maze_width  = r_mw;
    assign maze_height = r_mh;
    assign busy        = r_busy;
    assign done        = r_done;
    assign valid       = r_valid;

endmodule
